fetch_ctrl: RTL and testbench

Instruction-fetch controller sitting directly upstream of `pc_file`. Each cycle it computes the next PC (sequential or branch-redirected) and drives `pc_file`'s `i_pc`/`hold` pair so the PC advances only when a fetch completes. It issues word reads to instruction memory at the current PC and holds returned words in a 2-entry prefetch buffer drained by the decoder. A taken branch flushes the buffer and cancels any pending fetch.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's PC, instruction-memory, redirect and decoder signals.
// The master modport is the fetch controller; the slave modport is its environment.
interface fetch_ctrl_if;
    logic [15:0] i_pc;
    logic [15:0] o_npc;
    logic        o_hold;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic        br_take;
    logic [15:0] br_target;
    logic        dec_ready;
    logic        o_ir_valid;
    logic [15:0] o_ir;
    logic [15:0] o_ir_pc;

    modport master (
        input  i_pc, mem_ready, mem_data, br_take, br_target, dec_ready,
        output o_npc, o_hold, mem_req, mem_addr, o_ir_valid, o_ir, o_ir_pc
    );

    modport slave (
        output i_pc, mem_ready, mem_data, br_take, br_target, dec_ready,
        input  o_npc, o_hold, mem_req, mem_addr, o_ir_valid, o_ir, o_ir_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC file, issues word reads at the current PC
// and keeps a 2-entry prefetch buffer for the decoder; a taken branch flushes everything.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

    state_t      state;
    logic        head_valid;
    logic [15:0] head_ir;
    logic [15:0] head_pc;
    logic        tail_valid;
    logic [15:0] tail_ir;
    logic [15:0] tail_pc;

    logic        flush;
    logic        push;
    logic        pop;

    // A redirect during BOOT is ignored, so flush only exists outside BOOT.
    always_comb begin
        flush = bus.br_take && (state != BOOT);
        push  = (state == FETCH) && bus.mem_ready && !flush;
        pop   = head_valid && bus.dec_ready && !flush;
    end

    assign bus.mem_req    = (state == FETCH);
    assign bus.mem_addr   = bus.i_pc;
    assign bus.o_npc      = bus.br_take ? bus.br_target : bus.i_pc + 16'd1;
    assign bus.o_hold     = !(flush || ((state == FETCH) && bus.mem_ready));
    assign bus.o_ir_valid = head_valid;
    assign bus.o_ir       = head_ir;
    assign bus.o_ir_pc    = head_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            head_valid <= 1'b0;
            head_ir    <= 16'h0000;
            head_pc    <= 16'h0000;
            tail_valid <= 1'b0;
            tail_ir    <= 16'h0000;
            tail_pc    <= 16'h0000;
        end else begin
            // FULL is entered only when the buffer is at two entries after this edge,
            // and left as soon as a pop or a flush frees a slot.
            case (state)
                BOOT:    state <= FETCH;
                FETCH:   if (!flush && push && !pop && head_valid) state <= FULL;
                FULL:    if (flush || pop) state <= FETCH;
                default: state <= BOOT;
            endcase

            if (flush) begin
                head_valid <= 1'b0;
                tail_valid <= 1'b0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (!head_valid) begin
                            head_valid <= 1'b1;
                            head_ir    <= bus.mem_data;
                            head_pc    <= bus.i_pc;
                        end else begin
                            tail_valid <= 1'b1;
                            tail_ir    <= bus.mem_data;
                            tail_pc    <= bus.i_pc;
                        end
                    end
                    2'b01: begin
                        head_valid <= tail_valid;
                        head_ir    <= tail_ir;
                        head_pc    <= tail_pc;
                        tail_valid <= 1'b0;
                    end
                    2'b11: begin
                        if (tail_valid) begin
                            head_ir <= tail_ir;
                            head_pc <= tail_pc;
                            tail_ir <= bus.mem_data;
                            tail_pc <= bus.i_pc;
                        end else begin
                            head_ir <= bus.mem_data;
                            head_pc <= bus.i_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written corner sequences
// and a randomized phase, all checked against a queue-based model and a pc_file model.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        mr;
        logic [15:0] md;
        logic        bt;
        logic [15:0] bta;
        logic        dr;
        logic        exp_req;
        logic        exp_hold;
        logic        exp_valid;
        logic [15:0] exp_addr;
        logic [15:0] exp_npc;
        logic [15:0] exp_ir;
        logic [15:0] exp_ir_pc;
    } vec_t;

    entry_t      q[$];
    vec_t        vecs[14];
    bit          boot;
    bit          just_reset;
    logic [15:0] pc;
    logic [15:0] pc_reset;
    int          tests;
    int          failures;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic mr, input logic [15:0] md,
                                  input logic bt, input logic [15:0] bta, input logic dr);
        rst           = r;
        bus.mem_ready = mr;
        bus.mem_data  = md;
        bus.br_take   = bt;
        bus.br_target = bta;
        bus.dec_ready = dr;
        bus.i_pc      = pc;
    endtask

    // Model view: BOOT for one cycle after reset, otherwise fetching whenever fewer than two words are buffered.
    task automatic check_output();
        logic        exp_req;
        logic        exp_hold;
        logic [15:0] exp_npc;
        exp_req  = !boot && (q.size() < 2);
        exp_hold = !((bus.br_take && !boot) || (exp_req && bus.mem_ready));
        exp_npc  = bus.br_take ? bus.br_target : pc + 16'd1;
        cmp("mem_req", {15'd0, bus.mem_req}, {15'd0, exp_req});
        cmp("o_hold", {15'd0, bus.o_hold}, {15'd0, exp_hold});
        cmp("o_npc", bus.o_npc, exp_npc);
        cmp("mem_addr", bus.mem_addr, pc);
        cmp("o_ir_valid", {15'd0, bus.o_ir_valid}, {15'd0, q.size() > 0});
        if (q.size() > 0) begin
            cmp("o_ir", bus.o_ir, q[0].ir);
            cmp("o_ir_pc", bus.o_ir_pc, q[0].pc);
        end
        if (just_reset) begin
            cmp("o_ir_reset", bus.o_ir, 16'h0000);
            cmp("o_ir_pc_reset", bus.o_ir_pc, 16'h0000);
        end
    endtask

    // Advance the model and the pc_file across one rising edge.
    task automatic tick();
        logic        hold;
        logic [15:0] npc;
        bit          do_push;
        bit          do_pop;
        hold    = bus.o_hold;
        npc     = bus.o_npc;
        do_push = !boot && (q.size() < 2) && bus.mem_ready;
        do_pop  = (q.size() > 0) && bus.dec_ready;
        if (rst) begin
            boot       = 1'b1;
            just_reset = 1'b1;
            q.delete();
            pc = pc_reset;
        end else begin
            just_reset = 1'b0;
            if (boot) begin
                boot = 1'b0;
            end else if (bus.br_take) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{pc, bus.mem_data});
            end
            if (!hold) pc = npc;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        failures   = 0;
        pc         = 16'h0000;
        pc_reset   = 16'h4FF0;
        boot       = 1'b1;
        just_reset = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4FF0, 16'h4FF1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4FF0, 16'h4FF1, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h1001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4FF0, 16'h4FF1, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 16'h1002, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4FF1, 16'h4FF2, 16'h1001, 16'h4FF0};
        vecs[4]  = '{1'b0, 1'b1, 16'h1003, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4FF2, 16'h4FF3, 16'h1002, 16'h4FF1};
        vecs[5]  = '{1'b0, 1'b1, 16'h1004, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4FF3, 16'h4FF4, 16'h1002, 16'h4FF1};
        vecs[6]  = '{1'b0, 1'b1, 16'h1005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4FF3, 16'h4FF4, 16'h1002, 16'h4FF1};
        for (int i = 7; i < 10; i++)
            vecs[i] = '{1'b0, 1'b0, 16'h1006, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4FF3, 16'h4FF4, 16'h1003, 16'h4FF2};
        vecs[10] = '{1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4FF3, 16'h4FF4, 16'h1003, 16'h4FF2};
        vecs[11] = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4FF4, 16'h1234, 16'h1003, 16'h4FF2};
        vecs[12] = '{1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1235, 16'h0000, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 16'h3001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1235, 16'h1236, 16'h3000, 16'h1234};

        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tick();

        // Stream, backpressure, wait states and branch flush with hand-derived expectations.
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].mr, vecs[i].md, vecs[i].bt, vecs[i].bta, vecs[i].dr);
            @(negedge clk);
            check_output();
            cmp($sformatf("vec%0d_req", i), {15'd0, bus.mem_req}, {15'd0, vecs[i].exp_req});
            cmp($sformatf("vec%0d_hold", i), {15'd0, bus.o_hold}, {15'd0, vecs[i].exp_hold});
            cmp($sformatf("vec%0d_valid", i), {15'd0, bus.o_ir_valid}, {15'd0, vecs[i].exp_valid});
            cmp($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
            cmp($sformatf("vec%0d_npc", i), bus.o_npc, vecs[i].exp_npc);
            if (vecs[i].exp_valid) begin
                cmp($sformatf("vec%0d_ir", i), bus.o_ir, vecs[i].exp_ir);
                cmp($sformatf("vec%0d_ir_pc", i), bus.o_ir_pc, vecs[i].exp_ir_pc);
            end
            tick();
        end

        // Wrap: fetching at 0xFFFF must step the PC to 0x0000.
        pc = 16'hFFFF;
        apply_stimulus(1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        check_output();
        cmp("wrap_npc", bus.o_npc, 16'h0000);
        cmp("wrap_hold", {15'd0, bus.o_hold}, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        check_output();
        cmp("wrap_addr", bus.mem_addr, 16'h0000);
        cmp("wrap_ir_pc", bus.o_ir_pc, 16'hFFFF);
        cmp("wrap_ir", bus.o_ir, 16'hABCD);
        tick();

        // Reset mid-stream with one buffered word and a read completing at that edge.
        apply_stimulus(1'b1, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check_output();
        cmp("pre_reset_valid", {15'd0, bus.o_ir_valid}, 16'h0001);
        tick();
        apply_stimulus(1'b0, 1'b1, 16'h8888, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        check_output();
        cmp("post_reset_req", {15'd0, bus.mem_req}, 16'h0000);
        cmp("post_reset_hold", {15'd0, bus.o_hold}, 16'h0001);
        cmp("post_reset_valid", {15'd0, bus.o_ir_valid}, 16'h0000);
        cmp("post_reset_ir", bus.o_ir, 16'h0000);
        cmp("post_reset_ir_pc", bus.o_ir_pc, 16'h0000);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic        r;
            logic        bt;
            logic [15:0] bta;
            r   = ($urandom_range(0, 199) == 0);
            bt  = ($urandom_range(0, 15) == 0);
            bta = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
            if (r) pc_reset = 16'($urandom);
            apply_stimulus(r, $urandom_range(0, 9) < 7, 16'($urandom), bt, bta, $urandom_range(0, 9) < 6);
            @(negedge clk);
            check_output();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
